// File: rtl/acp_burst_feeder.sv
// acp_burst_feeder: FWFT FIFO and burst command FSM ahead of the PS ACP write tx stage.
// Define ACP_FEED_STATS_EN to add the stat_bursts / stat_drops counters.
module acp_burst_feeder #(
    parameter int FIFO_AW   = 6,
    parameter int BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [31:0]        cfg_base,
    input  logic [31:0]        cfg_size,
    input  logic [63:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               tx_en,
    input  logic               tx_rdy,
    output logic [31:0]        tx_awaddr,
    output logic [2:0]         tx_awid,
    output logic [63:0]        tx_wdata,
    input  logic               tx_wdreq,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               err_underrun
`ifdef ACP_FEED_STATS_EN
    ,
    output logic [31:0]        stat_bursts,
    output logic [31:0]        stat_drops
`endif
);
    // state  | meaning
    // S_IDLE | waiting for enable, tx_rdy and a full uncommitted burst in the FIFO
    // S_BUSY | tx_en issued, waiting for the tx stage to drop tx_rdy (4-cycle timeout)
    // S_WAIT | burst accepted, beats being drained, waiting for tx_rdy to return
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int OW = FIFO_AW + 1;
    localparam int LW = FIFO_AW + 2;
    localparam logic [OW-1:0] BURST_W   = OW'(BURST_LEN);
    localparam logic [31:0]   ALIGN_MSK = 32'hFFFF_FF80;

    logic [63:0]        mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    logic [1:0]         state;
    logic [1:0]         tmr;
    logic               en_d;
    logic               en_rise;
    logic               cfg_pend;
    logic [31:0]        pend_base;
    logic [31:0]        pend_size;
    logic [31:0]        base_r;
    logic [31:0]        size_r;
    logic [31:0]        offset_r;
    logic [31:0]        off_nxt;
    logic [32:0]        off_sum;
    logic [2:0]         next_id;
    logic [OW-1:0]      outstanding;
    logic [OW-1:0]      out_nxt;
    logic               credit_ok;
    logic               launch;
    logic               timeout;

    assign empty    = (fifo_level == '0);
    assign full     = fifo_level[FIFO_AW];
    assign pop      = tx_wdreq & ~empty;
    assign in_ready = ~full | pop;
    assign push     = in_valid & in_ready;
    assign tx_wdata = empty ? 64'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)      fifo_level <= fifo_level + OW'(1);
            else if (pop && !push) fifo_level <= fifo_level - OW'(1);
        end
    end

    // Words already promised to an issued burst are excluded from the launch check.
    assign credit_ok = LW'(fifo_level) >= (LW'(BURST_W) + LW'(outstanding));
    assign en_rise   = enable & ~en_d;
    assign launch    = (state == S_IDLE) & enable & tx_rdy & credit_ok & ~en_rise & ~cfg_pend;
    assign timeout   = (state == S_BUSY) & tx_rdy & (tmr == 2'd0);
    assign off_sum   = {1'b0, offset_r} + 33'd128;
    assign off_nxt   = (off_sum >= {1'b0, size_r}) ? 32'd0 : off_sum[31:0];

    always_comb begin
        out_nxt = outstanding;
        if (pop && outstanding != '0) out_nxt = outstanding - OW'(1);
        if (launch)       out_nxt = out_nxt + BURST_W;
        else if (timeout) out_nxt = (out_nxt >= BURST_W) ? out_nxt - BURST_W : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmr          <= 2'd0;
            en_d         <= 1'b0;
            cfg_pend     <= 1'b0;
            pend_base    <= 32'd0;
            pend_size    <= 32'd0;
            base_r       <= 32'd0;
            size_r       <= 32'd0;
            offset_r     <= 32'd0;
            next_id      <= 3'd0;
            outstanding  <= '0;
            tx_en        <= 1'b0;
            tx_awaddr    <= 32'd0;
            tx_awid      <= 3'd0;
            err_underrun <= 1'b0;
        end else begin
            en_d        <= enable;
            tx_en       <= 1'b0;
            outstanding <= out_nxt;
            if ((tx_wdreq && empty) || timeout) err_underrun <= 1'b1;

            if (en_rise && state != S_IDLE) begin
                cfg_pend  <= 1'b1;
                pend_base <= cfg_base & ALIGN_MSK;
                pend_size <= cfg_size & ALIGN_MSK;
            end

            case (state)
                S_IDLE: begin
                    if (en_rise) begin
                        base_r   <= cfg_base & ALIGN_MSK;
                        size_r   <= cfg_size & ALIGN_MSK;
                        offset_r <= 32'd0;
                    end else if (cfg_pend) begin
                        base_r   <= pend_base;
                        size_r   <= pend_size;
                        offset_r <= 32'd0;
                        cfg_pend <= 1'b0;
                    end else if (launch) begin
                        tx_en     <= 1'b1;
                        tx_awaddr <= base_r + offset_r;
                        tx_awid   <= next_id;
                        tmr       <= 2'd3;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!tx_rdy) begin
                        state <= S_WAIT;
                    end else if (tmr == 2'd0) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 2'd1;
                    end
                end
                S_WAIT: begin
                    if (tx_rdy) begin
                        offset_r <= off_nxt;
                        next_id  <= next_id + 3'd1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ACP_FEED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts <= 32'd0;
            stat_drops  <= 32'd0;
        end else begin
            if (launch)               stat_bursts <= stat_bursts + 32'd1;
            if (in_valid && !in_ready) stat_drops <= stat_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acp_burst_feeder.sv
// Scoreboard bench for acp_burst_feeder: data words and burst commands are predicted as stimulus is driven.
module tb_acp_burst_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] cfg_base = 32'd0;
    logic [31:0] cfg_size = 32'd0;
    logic [63:0] in_data = 64'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx_en;
    logic        tx_rdy = 1'b1;
    logic [31:0] tx_awaddr;
    logic [2:0]  tx_awid;
    logic [63:0] tx_wdata;
    logic        tx_wdreq = 1'b0;
    logic [6:0]  fifo_level;
    logic        err_underrun;
`ifdef ACP_FEED_STATS_EN
    logic [31:0] stat_bursts;
    logic [31:0] stat_drops;
`endif

    acp_burst_feeder #(.FIFO_AW(6), .BURST_LEN(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_base(cfg_base), .cfg_size(cfg_size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .tx_en(tx_en),
        .tx_rdy(tx_rdy), .tx_awaddr(tx_awaddr), .tx_awid(tx_awid), .tx_wdata(tx_wdata),
        .tx_wdreq(tx_wdreq), .fifo_level(fifo_level), .err_underrun(err_underrun)
`ifdef ACP_FEED_STATS_EN
        , .stat_bursts(stat_bursts), .stat_drops(stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] mbase = 32'd0;
    logic [31:0] msize = 32'd0;
    logic [31:0] moff = 32'd0;
    logic [2:0]  mid = 3'd0;
    int          mbursts = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] d, output logic acc);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        acc = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_burst(input int n, output int nacc);
        logic [63:0] d;
        logic        acc;
        nacc = 0;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            exp_q.push_back(d);
            push_word(d, acc);
            if (acc === 1'b1) nacc++;
        end
    endtask

    task automatic wait_tx_en(input int max_cyc, output logic seen, output logic [31:0] a,
                              output logic [2:0] id);
        seen = 1'b0;
        a    = 32'd0;
        id   = 3'd0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                seen = 1'b1;
                a    = tx_awaddr;
                id   = tx_awid;
            end
        end
        tick();
    endtask

    task automatic serve_beats(input int n);
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            tx_wdreq = 1'b1;
            @(negedge clk);
            obs_q.push_back(tx_wdata);
            tick();
        end
        tx_wdreq = 1'b0;
    endtask

    task automatic adv_ring;
        logic [32:0] s;
        s    = {1'b0, moff} + 33'd128;
        moff = (s >= {1'b0, msize}) ? 32'd0 : s[31:0];
        mid  = mid + 3'd1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
        n_cmp++; if (tx_awaddr !== 32'd0) begin n_err++; $display("FAIL reset_awaddr got %h want 0", tx_awaddr); end
        n_cmp++; if (tx_awid !== 3'd0) begin n_err++; $display("FAIL reset_awid got %0d want 0", tx_awid); end
        n_cmp++; if (tx_wdata !== 64'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", tx_wdata); end
        n_cmp++; if (fifo_level !== 7'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_underrun); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_burst;
        int          nacc;
        logic        seen;
        logic [31:0] a;
        logic [2:0]  id;
        logic [63:0] e;
        cfg_base = 32'h1000_0000;
        cfg_size = 32'h0000_0400;
        mbase = cfg_base; msize = cfg_size; moff = 32'd0;
        tx_rdy = 1'b1;
        enable = 1'b1;
        push_burst(16, nacc);
        n_cmp++; if (nacc !== 16) begin n_err++; $display("FAIL single_accept got %0d want 16", nacc); end
        wait_tx_en(40, seen, a, id);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL single_tx_en got %b want 1", seen); end
        n_cmp++; if (a !== mbase + moff) begin n_err++; $display("FAIL single_awaddr got %h want %h", a, mbase + moff); end
        n_cmp++; if (id !== mid) begin n_err++; $display("FAIL single_awid got %0d want %0d", id, mid); end
        mbursts++;
        tx_rdy = 1'b0;
        serve_beats(16);
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[i] !== e) begin n_err++; $display("FAIL single_wdata[%0d] got %h want %h", i, obs_q[i], e); end
        end
        n_cmp++; if (fifo_level !== 7'd0) begin n_err++; $display("FAIL single_level got %0d want 0", fifo_level); end
        tx_rdy = 1'b1;
        tick();
        adv_ring();
    endtask

    task automatic test_ring_wrap;
        int          nacc;
        logic        seen;
        logic [31:0] a;
        logic [2:0]  id;
        logic [63:0] e;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        moff = 32'd0;
        tick();
        for (int b = 0; b < 9; b++) begin
            push_burst(16, nacc);
            n_cmp++; if (nacc !== 16) begin n_err++; $display("FAIL ring_accept[%0d] got %0d want 16", b, nacc); end
            wait_tx_en(40, seen, a, id);
            n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL ring_tx_en[%0d] got %b want 1", b, seen); end
            n_cmp++; if (a !== mbase + moff) begin n_err++; $display("FAIL ring_awaddr[%0d] got %h want %h", b, a, mbase + moff); end
            n_cmp++; if (id !== mid) begin n_err++; $display("FAIL ring_awid[%0d] got %0d want %0d", b, id, mid); end
            mbursts++;
            tx_rdy = 1'b0;
            serve_beats(16);
            foreach (obs_q[i]) begin
                e = exp_q.pop_front();
                n_cmp++; if (obs_q[i] !== e) begin n_err++; $display("FAIL ring_wdata[%0d][%0d] got %h want %h", b, i, obs_q[i], e); end
            end
            tx_rdy = 1'b1;
            tick();
            adv_ring();
        end
    endtask

    task automatic test_full;
        int          nacc;
        logic        acc;
        logic [63:0] d;
        logic [63:0] e;
`ifdef ACP_FEED_STATS_EN
        logic [31:0] d0;
`endif
        enable = 1'b0;
        tick();
        push_burst(64, nacc);
        n_cmp++; if (nacc !== 64) begin n_err++; $display("FAIL full_accept got %0d want 64", nacc); end
        @(negedge clk);
        n_cmp++; if (fifo_level !== 7'd64) begin n_err++; $display("FAIL full_level got %0d want 64", fifo_level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        tick();
`ifdef ACP_FEED_STATS_EN
        d0 = stat_drops;
`endif
        for (int i = 0; i < 3; i++) begin
            push_word({$urandom, $urandom}, acc);
            n_cmp++; if (acc !== 1'b0) begin n_err++; $display("FAIL full_stall[%0d] got %b want 0", i, acc); end
        end
`ifdef ACP_FEED_STATS_EN
        n_cmp++; if (stat_drops - d0 !== 32'd3) begin n_err++; $display("FAIL full_drops got %0d want 3", stat_drops - d0); end
`endif
        d = {$urandom, $urandom};
        in_valid = 1'b1;
        in_data  = d;
        tx_wdreq = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        exp_q.push_back(d);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pushpop_ready got %b want 1", in_ready); end
        n_cmp++; if (tx_wdata !== e) begin n_err++; $display("FAIL full_pushpop_wdata got %h want %h", tx_wdata, e); end
        tick();
        in_valid = 1'b0;
        tx_wdreq = 1'b0;
        n_cmp++; if (fifo_level !== 7'd64) begin n_err++; $display("FAIL full_pushpop_level got %0d want 64", fifo_level); end
        serve_beats(64);
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[i] !== e) begin n_err++; $display("FAIL full_wdata[%0d] got %h want %h", i, obs_q[i], e); end
        end
        n_cmp++; if (fifo_level !== 7'd0) begin n_err++; $display("FAIL full_drain_level got %0d want 0", fifo_level); end
        n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL full_err got %b want 0", err_underrun); end
    endtask

    task automatic test_underrun_reset;
        int          nacc;
        logic        seen;
        logic [31:0] a;
        logic [2:0]  id;
        tx_wdreq = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_wdata !== 64'd0) begin n_err++; $display("FAIL under_wdata got %h want 0", tx_wdata); end
        tick();
        tx_wdreq = 1'b0;
        n_cmp++; if (fifo_level !== 7'd0) begin n_err++; $display("FAIL under_level got %0d want 0", fifo_level); end
        n_cmp++; if (err_underrun !== 1'b1) begin n_err++; $display("FAIL under_err got %b want 1", err_underrun); end
        enable = 1'b1;
        moff = 32'd0;
        push_burst(16, nacc);
        wait_tx_en(40, seen, a, id);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstmid_tx_en got %b want 1", seen); end
        tx_rdy = 1'b0;
        serve_beats(5);
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (tx_awaddr !== 32'd0) begin n_err++; $display("FAIL rstmid_awaddr got %h want 0", tx_awaddr); end
        n_cmp++; if (tx_awid !== 3'd0) begin n_err++; $display("FAIL rstmid_awid got %0d want 0", tx_awid); end
        n_cmp++; if (fifo_level !== 7'd0) begin n_err++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
        n_cmp++; if (tx_wdata !== 64'd0) begin n_err++; $display("FAIL rstmid_wdata got %h want 0", tx_wdata); end
        n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL rstmid_err got %b want 0", err_underrun); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        n_cmp++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_en_low got %b want 0", tx_en); end
        exp_q.delete();
        obs_q.delete();
        moff = 32'd0;
        mid = 3'd0;
        mbursts = 0;
        tick();
        rst = 1'b0;
        tx_rdy = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_enable_drop;
        int          nacc;
        logic        seen;
        logic [31:0] a;
        logic [2:0]  id;
        logic [63:0] e;
        push_burst(16, nacc);
        wait_tx_en(40, seen, a, id);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL endrop_tx_en got %b want 1", seen); end
        n_cmp++; if (a !== mbase + moff) begin n_err++; $display("FAIL endrop_awaddr got %h want %h", a, mbase + moff); end
        mbursts++;
        enable = 1'b0;
        tx_rdy = 1'b0;
        push_burst(16, nacc);
        n_cmp++; if (nacc !== 16) begin n_err++; $display("FAIL endrop_accept got %0d want 16", nacc); end
        serve_beats(16);
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[i] !== e) begin n_err++; $display("FAIL endrop_wdata[%0d] got %h want %h", i, obs_q[i], e); end
        end
        tx_rdy = 1'b1;
        tick();
        adv_ring();
        wait_tx_en(30, seen, a, id);
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL endrop_no_tx_en got %b want 0", seen); end
        enable = 1'b1;
        moff = 32'd0;
        wait_tx_en(40, seen, a, id);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL enrise_tx_en got %b want 1", seen); end
        n_cmp++; if (a !== mbase + moff) begin n_err++; $display("FAIL enrise_awaddr got %h want %h", a, mbase + moff); end
        n_cmp++; if (id !== mid) begin n_err++; $display("FAIL enrise_awid got %0d want %0d", id, mid); end
        mbursts++;
        tx_rdy = 1'b0;
        serve_beats(16);
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[i] !== e) begin n_err++; $display("FAIL enrise_wdata[%0d] got %h want %h", i, obs_q[i], e); end
        end
        tx_rdy = 1'b1;
        tick();
        adv_ring();
    endtask

    task automatic test_timeout;
        int          nacc;
        logic        seen;
        logic [31:0] a;
        logic [2:0]  id;
        logic [63:0] e;
        n_cmp++; if (err_underrun !== 1'b0) begin n_err++; $display("FAIL tmo_err_pre got %b want 0", err_underrun); end
        push_burst(16, nacc);
        wait_tx_en(40, seen, a, id);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL tmo_first_tx_en got %b want 1", seen); end
        mbursts++;
        wait_tx_en(40, seen, a, id);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL tmo_retry_tx_en got %b want 1", seen); end
        n_cmp++; if (a !== mbase + moff) begin n_err++; $display("FAIL tmo_awaddr got %h want %h", a, mbase + moff); end
        n_cmp++; if (id !== mid) begin n_err++; $display("FAIL tmo_awid got %0d want %0d", id, mid); end
        n_cmp++; if (err_underrun !== 1'b1) begin n_err++; $display("FAIL tmo_err got %b want 1", err_underrun); end
        mbursts++;
        tx_rdy = 1'b0;
        serve_beats(16);
        foreach (obs_q[i]) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs_q[i] !== e) begin n_err++; $display("FAIL tmo_wdata[%0d] got %h want %h", i, obs_q[i], e); end
        end
        tx_rdy = 1'b1;
        tick();
        adv_ring();
`ifdef ACP_FEED_STATS_EN
        n_cmp++; if (stat_bursts !== 32'(mbursts)) begin n_err++; $display("FAIL stat_bursts got %0d want %0d", stat_bursts, mbursts); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_ring_wrap();
        test_full();
        test_underrun_reset();
        test_enable_drop();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
